// File: rtl/chain_spi_master.sv
// SPI-style master for the scan-chain slave: shifts a word out MSB first
// under nCS, pulses nCS high to latch, and returns the shifted-out word.
module chain_spi_master #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_tx_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_spi_clk,
    output logic             o_spi_dat,
    output logic             o_spi_load,
    input  logic             i_spi_dat
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             load_q, load_d;
    logic             phase_end;

    assign phase_end = (cnt_q == CNT_MAX);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            load_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            load_q    <= load_d;
        end
    end

    // MISO is captured on the edge that raises SCLK, before the slave shifts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        if (state_q != S_IDLE) begin
            cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    tx_d    = i_tx_data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_HIGH;
                    rx_d    = {rx_q[WIDTH-2:0], i_spi_dat};
                    bit_d   = bit_q + BIT_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    state_d = S_LOW;
                    if (bit_q != BIT_LAST) begin
                        tx_d = {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_HIGH;
                        rx_d    = {rx_q[WIDTH-2:0], i_spi_dat};
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                if (phase_end) begin
                    state_d   = S_IDLE;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    bit_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pins are registered from the next state so they never glitch.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        sclk_d = (state_d == S_HIGH);
        load_d = (state_d == S_IDLE) || (state_d == S_FINISH);
        mosi_d = (state_d == S_IDLE) ? 1'b0 : tx_d[WIDTH-1];
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rx_data  = rx_data_q;
    assign o_spi_clk  = sclk_q;
    assign o_spi_dat  = mosi_q;
    assign o_spi_load = load_q;

endmodule
